rv_mem_arb: RTL

- Arbiter and sequencer for the single-port unified memory of the multicycle RISC-V core.
- Shares the memory between two requesters: the core port (fetch and load/store) and a DMA/loader port.
- Issues one access at a time and waits a fixed memory latency. Returns read data with a one-cycle ready pulse to the winning requester.
- Fixed priority goes to the core. An anti-starvation counter bounds how long the DMA port can wait.

---
 rtl/rv_mem_arb_if.sv | 51 +++++
 rtl/rv_mem_arb.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb_if.sv
// Bus bundle between the two requesters (core, DMA/loader), the arbiter and
// the single-port unified memory.
// Handshake: a requester raises *_req together with *_we/*_addr/*_wdata and
// holds all of them stable until it sees a one-cycle *_ready pulse, at which
// point *_rdata is valid (reads) and stays held until the next completed read.
// mem_en is a single-cycle strobe per access; mem_rdata is valid MEM_LAT
// cycles after it.
interface rv_mem_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_ready;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and memory side (environment).
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ready,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ready,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one single-port memory between the core and a DMA port.
// One access at a time: IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (latency)
// -> RESP (ready pulse). Core has fixed priority; starve_q counts core grants
// made while DMA was waiting and forces a DMA grant once it hits STARVE_LIM.
module rv_mem_arb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  rv_mem_arb_if.slave bus,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;      // 0 = core, 1 = dma
  logic [3:0]        starve_q, starve_d;
  logic [3:0]        lat_q, lat_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              core_ready_q, core_ready_d;
  logic              dma_ready_q, dma_ready_d;
  logic              grant_dma;

  // Next-state, arbitration and access sequencing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    lat_d        = lat_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    mem_en_d     = 1'b0;
    core_ready_d = 1'b0;
    dma_ready_d  = 1'b0;
    grant_dma    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.core_req || bus.dma_req) begin
          // DMA wins when alone, or when core has starved it long enough.
          grant_dma = bus.dma_req && (!bus.core_req || starve_q == STARVE_MAX);
          owner_d   = grant_dma;
          we_d      = grant_dma ? bus.dma_we    : bus.core_we;
          addr_d    = grant_dma ? bus.dma_addr  : bus.core_addr;
          wdata_d   = grant_dma ? bus.dma_wdata : bus.core_wdata;
          if (!grant_dma && bus.dma_req) begin
            starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
          mem_en_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q) dma_rdata_d  = bus.mem_rdata;
            else         core_rdata_d = bus.mem_rdata;
          end
          core_ready_d = !owner_q;
          dma_ready_d  = owner_q;
          state_d      = RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_q     <= 4'd0;
      lat_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      core_ready_q <= 1'b0;
      dma_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      lat_q        <= lat_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      mem_en_q     <= mem_en_d;
      core_ready_q <= core_ready_d;
      dma_ready_q  <= dma_ready_d;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.core_ready = core_ready_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_ready  = dma_ready_q;
  assign dbg_state      = state_q;
endmodule
